// File: rtl/steering_delay_gen.sv
// Beam-steering delay generator for an N-element uniform linear array.
// One shared multiply, then a restoring divide per mic with rounding and saturation.
`timescale 1ns/1ps
module steering_delay_gen #(
    parameter int NUM_MICS         = 4,
    parameter int DELAY_W          = 16,
    parameter int ACC_W            = 32,
    parameter int SAMPLE_PERIOD_NS = 20833
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         start_in,
    input  logic [7:0]                   angle_in,
    input  logic [15:0]                  distance_in,
    input  logic                         units_sel_in,
    output logic                         ready_out,
    output logic                         valid_out,
    output logic                         err_out,
    output logic                         sat_out,
    output logic [NUM_MICS*DELAY_W-1:0]  delays_out
);

    localparam int MIC_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
    localparam int BIT_W = $clog2(ACC_W);
    localparam logic [ACC_W-1:0] DELAY_MAX = ACC_W'((64'd1 << DELAY_W) - 64'd1);
    localparam logic [ACC_W-1:0] D_US      = ACC_W'(1000);
    localparam logic [ACC_W-1:0] D_SAMPLE  = ACC_W'(SAMPLE_PERIOD_NS);

    // round(1e6/343 * cos(a deg)) via a 1e9-scaled Taylor series, folded about 90 deg.
    function automatic int cos_ns_per_mm(input int a);
        longint x, x2, term, sum;
        int     b, v;
        b    = (a > 90) ? 180 - a : a;
        x    = longint'(b) * 64'sd3141592654 / 64'sd180;
        x2   = x * x / 64'sd1000000000;
        term = 64'sd1000000000;
        sum  = term;
        for (int n = 1; n <= 10; n++) begin
            term = -(term * x2 / 64'sd1000000000) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        v = int'((sum + 64'sd171500) / 64'sd343000);
        return (a > 90) ? -v : v;
    endfunction

    function automatic logic [DELAY_W-1:0] sat_delay(input logic [ACC_W-1:0] q);
        return (q > DELAY_MAX) ? {DELAY_W{1'b1}} : q[DELAY_W-1:0];
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_WRITE, S_DONE} state_t;

    logic signed [12:0] cos_tab [256];

    for (genvar a = 0; a < 256; a++) begin : g_cos
        localparam int COS_V = (a <= 180) ? cos_ns_per_mm(a) : 0;
        assign cos_tab[a] = 13'(COS_V);
    end

    state_t             state;
    logic [7:0]         angle_r;
    logic [15:0]        dist_r;
    logic [ACC_W-1:0]   div_d;
    logic               mirror_r;
    logic               err_r;
    logic               sat_r;
    logic [ACC_W-1:0]   prod_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   quo_r;
    logic [ACC_W-1:0]   rem_r;
    logic [BIT_W-1:0]   bit_cnt;
    logic [MIC_W-1:0]   mic_cnt;
    logic [DELAY_W-1:0] shadow [NUM_MICS];

    logic signed [12:0] cos_sel;
    logic [ACC_W-1:0]   cos_mag;
    logic [ACC_W-1:0]   product;
    logic [ACC_W:0]     rem_shift;
    logic [ACC_W:0]     rem_sub;
    logic               rem_ge;
    logic [ACC_W-1:0]   acc_next;
    logic [MIC_W-1:0]   shadow_idx;

    always_comb begin
        cos_sel = cos_tab[angle_r];
        cos_mag = '0;
        if (cos_sel < 0) cos_mag = ACC_W'($unsigned(-cos_sel));
        else             cos_mag = ACC_W'($unsigned(cos_sel));
        product   = ACC_W'(dist_r) * cos_mag;
        rem_shift = {rem_r, quo_r[ACC_W-1]};
        rem_ge    = rem_shift >= {1'b0, div_d};
        rem_sub   = rem_shift - {1'b0, div_d};
        acc_next  = acc_r + prod_r;
        // Dividends always step 0,P,2P,...; past 90 deg that sequence lands on mics N-1 down to 0.
        shadow_idx = mirror_r ? (MIC_W'(NUM_MICS - 1) - mic_cnt) : mic_cnt;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            ready_out  <= 1'b0;
            valid_out  <= 1'b0;
            err_out    <= 1'b0;
            sat_out    <= 1'b0;
            delays_out <= '0;
            angle_r    <= '0;
            dist_r     <= '0;
            div_d      <= '0;
            mirror_r   <= 1'b0;
            err_r      <= 1'b0;
            sat_r      <= 1'b0;
            prod_r     <= '0;
            acc_r      <= '0;
            quo_r      <= '0;
            rem_r      <= '0;
            bit_cnt    <= '0;
            mic_cnt    <= '0;
            for (int k = 0; k < NUM_MICS; k++) shadow[k] <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_out <= 1'b1;
                    if (start_in && ready_out) begin
                        ready_out <= 1'b0;
                        angle_r   <= angle_in;
                        dist_r    <= distance_in;
                        div_d     <= units_sel_in ? D_SAMPLE : D_US;
                        state     <= S_MULT;
                    end
                end
                S_MULT: begin
                    mirror_r <= angle_r > 8'd90;
                    if (angle_r > 8'd180) begin
                        err_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        err_r   <= 1'b0;
                        sat_r   <= 1'b0;
                        prod_r  <= product;
                        acc_r   <= '0;
                        quo_r   <= div_d >> 1;
                        rem_r   <= '0;
                        bit_cnt <= '0;
                        mic_cnt <= '0;
                        state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_r   <= rem_ge ? rem_sub[ACC_W-1:0] : rem_shift[ACC_W-1:0];
                    quo_r   <= {quo_r[ACC_W-2:0], rem_ge};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(ACC_W - 1)) state <= S_WRITE;
                end
                S_WRITE: begin
                    shadow[shadow_idx] <= sat_delay(quo_r);
                    if (quo_r > DELAY_MAX) sat_r <= 1'b1;
                    acc_r   <= acc_next;
                    quo_r   <= acc_next + (div_d >> 1);
                    rem_r   <= '0;
                    bit_cnt <= '0;
                    if (mic_cnt == MIC_W'(NUM_MICS - 1)) begin
                        state <= S_DONE;
                    end else begin
                        mic_cnt <= mic_cnt + MIC_W'(1);
                        state   <= S_DIV;
                    end
                end
                S_DONE: begin
                    valid_out <= 1'b1;
                    err_out   <= err_r;
                    if (err_r) begin
                        delays_out <= '0;
                        sat_out    <= 1'b0;
                    end else begin
                        for (int k = 0; k < NUM_MICS; k++)
                            delays_out[k*DELAY_W +: DELAY_W] <= shadow[k];
                        sat_out <= sat_r;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
